// File: rtl/capture_ctrl.sv
// capture_ctrl: sequencer for a circular multi-channel sample capture.
// Flow: start -> PRE (fill pretrigger region) -> ARM (wait for trigger)
//       -> POST (collect trig_pos samples) -> DONE (hold until done_clr).
// Kept samples (1 of every 2**dec_pwr valid strobes) write all RAMs
// selected by ch_mask at the shared address, which then advances with
// wrap-around.
// Handshake: inputs are single-cycle strobes with no ready; a kept sample
// is written in the same cycle it is presented (we/en are combinational).
// Optional feature: define CAPTURE_AUTOROLL_EN to let autoroll force the
// trigger while armed; otherwise autoroll is ignored.
module capture_ctrl #(
    parameter int ADDR_W = 9,
    parameter int NUM_CH = 3,
    parameter int DEC_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              smpl_vld,
    input  logic [DEC_W-1:0]  dec_pwr,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic              trigger,
    input  logic              autoroll,
    input  logic              start,
    input  logic              abort,
    input  logic              done_clr,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [ADDR_W-1:0] addr,
    output logic [NUM_CH-1:0] we,
    output logic [NUM_CH-1:0] en,
    output logic              armed,
    output logic              capture_done,
    output logic [ADDR_W-1:0] trace_end,
    output logic [2:0]        dbg_state
);

    localparam int CNT_W = 2**DEC_W;
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   SMP_ONE = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_ARM  = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  dec_cnt;
    logic [CNT_W-1:0]  dec_max;
    logic [ADDR_W:0]   smpl_cnt;
    logic [ADDR_W:0]   pre_target;
    logic [ADDR_W:0]   post_target;
    logic              active;
    logic              keep;
    logic              trig_eff;

    // Decimation terminal count and capture region sizes, taken live.
    assign dec_max     = (CNT_ONE << dec_pwr) - CNT_ONE;
    assign pre_target  = DEPTH_V - {1'b0, trig_pos};
    assign post_target = (trig_pos == '0) ? SMP_ONE : {1'b0, trig_pos};

    // A kept sample happens only while acquiring; abort suppresses it.
    assign active = (state == S_PRE) || (state == S_ARM) || (state == S_POST);
    assign keep   = active && smpl_vld && (dec_cnt == dec_max) && !abort;

    // RAM strobes follow the kept sample in the same cycle.
    assign we = keep ? ch_mask : '0;
    assign en = keep ? ch_mask : '0;

    assign dbg_state = state;

`ifdef CAPTURE_AUTOROLL_EN
    // Autoroll forces a trigger on every armed kept sample.
    assign trig_eff = trigger | autoroll;
`else
    // Autoroll has no effect in this build.
    logic unused_autoroll;
    assign unused_autoroll = autoroll;
    assign trig_eff = trigger;
`endif

    // Capture sequencer: state, counters, address and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            dec_cnt      <= '0;
            smpl_cnt     <= '0;
            addr         <= '0;
            trace_end    <= '0;
            armed        <= 1'b0;
            capture_done <= 1'b0;
        end else if (abort) begin
            state        <= S_IDLE;
            armed        <= 1'b0;
            capture_done <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_PRE;
                        dec_cnt  <= '0;
                        smpl_cnt <= '0;
                    end
                end
                S_PRE, S_ARM, S_POST: begin
                    if (smpl_vld) begin
                        dec_cnt <= keep ? '0 : dec_cnt + CNT_ONE;
                    end
                    if (keep) begin
                        addr <= addr + 1'b1;
                        if (state == S_PRE) begin
                            // Trigger is not looked at while filling pretrigger.
                            if (smpl_cnt + SMP_ONE == pre_target) begin
                                state    <= S_ARM;
                                armed    <= 1'b1;
                                smpl_cnt <= '0;
                            end else begin
                                smpl_cnt <= smpl_cnt + SMP_ONE;
                            end
                        end else if (state == S_ARM) begin
                            // The triggering sample is post sample 1.
                            if (trig_eff) begin
                                armed <= 1'b0;
                                if (post_target == SMP_ONE) begin
                                    state        <= S_DONE;
                                    capture_done <= 1'b1;
                                    trace_end    <= addr;
                                end else begin
                                    state    <= S_POST;
                                    smpl_cnt <= SMP_ONE;
                                end
                            end
                        end else begin
                            if (smpl_cnt + SMP_ONE == post_target) begin
                                state        <= S_DONE;
                                capture_done <= 1'b1;
                                trace_end    <= addr;
                            end else begin
                                smpl_cnt <= smpl_cnt + SMP_ONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (done_clr) begin
                        state        <= S_IDLE;
                        capture_done <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: randomized capture runs against a sample-index model.
// The model counts valid strobes and kept samples since start and derives
// every expectation (strobes, address, armed/done windows, trace_end) from
// those counts with plain arithmetic.
module tb_capture_ctrl;

  localparam int ADDR_W = 9;
  localparam int NUM_CH = 3;
  localparam int DEC_W  = 4;
  localparam int DEPTH  = 2**ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              smpl_vld;
  logic [DEC_W-1:0]  dec_pwr;
  logic [ADDR_W-1:0] trig_pos;
  logic              trigger;
  logic              autoroll;
  logic              start;
  logic              abort;
  logic              done_clr;
  logic [NUM_CH-1:0] ch_mask;
  logic [ADDR_W-1:0] addr;
  logic [NUM_CH-1:0] we;
  logic [NUM_CH-1:0] en;
  logic              armed;
  logic              capture_done;
  logic [ADDR_W-1:0] trace_end;
  logic [2:0]        dbg_state;

  int tests_run;
  int tests_failed;
  int model_addr;
  logic [ADDR_W-1:0] exp_q[$];

  capture_ctrl #(
    .ADDR_W(ADDR_W),
    .NUM_CH(NUM_CH),
    .DEC_W (DEC_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .smpl_vld    (smpl_vld),
    .dec_pwr     (dec_pwr),
    .trig_pos    (trig_pos),
    .trigger     (trigger),
    .autoroll    (autoroll),
    .start       (start),
    .abort       (abort),
    .done_clr    (done_clr),
    .ch_mask     (ch_mask),
    .addr        (addr),
    .we          (we),
    .en          (en),
    .armed       (armed),
    .capture_done(capture_done),
    .trace_end   (trace_end),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; smpl_vld = 1'b1; dec_pwr = '0; trig_pos = ADDR_W'(100);
    trigger = 1'b0; autoroll = 1'b0; start = 1'b0; abort = 1'b0;
    done_clr = 1'b0; ch_mask = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (addr !== '0 || trace_end !== '0 || armed !== 1'b0 || capture_done !== 1'b0
        || we !== '0 || en !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: addr=%0h te=%0h armed=%b done=%b we=%b en=%b, need all 0",
               addr, trace_end, armed, capture_done, we, en);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tests_run++;
      if (we !== '0 || en !== '0 || addr !== '0) begin
        tests_failed++;
        $display("FAIL idle_no_write: we=%b en=%b addr=%0h, need 0", we, en, addr);
      end
    end
    @(posedge clk); #1;
    smpl_vld = 1'b0;
    model_addr = 0;
  endtask

  // One acquisition. k = kept index carrying the trigger, ign = kept index
  // with a trigger that must be ignored, abort_at = kept index aborted (0 none).
  task automatic run_capture(input int dp, input int tp, input logic [NUM_CH-1:0] mask,
                             input int k_in, input int ign, input int abort_at,
                             input int pct, input logic ar);
    int d, pre_t, post_t, total, keeps, vcnt, cyc, base, k;
    bit is_keep, aborted;
    logic exp_armed;
    logic [NUM_CH-1:0] exp_we;
    logic [ADDR_W-1:0] exp_a, got_a;
    k = k_in;
    d = 1 << dp;
    pre_t = DEPTH - tp;
    post_t = (tp == 0) ? 1 : tp;
`ifdef CAPTURE_AUTOROLL_EN
    if (ar) k = pre_t + 1;
`endif
    total = k + post_t - 1;
    base = model_addr;
    exp_q.delete();
    dec_pwr = DEC_W'(dp); trig_pos = ADDR_W'(tp); ch_mask = mask; autoroll = ar;
    smpl_vld = 1'b0; trigger = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    keeps = 0; vcnt = 0; cyc = 0; aborted = 0;
    while (!aborted && keeps < total && cyc < 20000) begin
      cyc++;
      smpl_vld = ($urandom_range(0, 99) < pct);
      is_keep = smpl_vld && ((vcnt % d) == d - 1);
      if (is_keep && keeps + 1 == k) trigger = 1'b1;
      else if (is_keep && keeps + 1 > pre_t && keeps + 1 < k) trigger = 1'b0;
      else if (is_keep && keeps + 1 == ign) trigger = 1'b1;
      else trigger = 1'($urandom_range(0, 1));
      abort = is_keep && (keeps + 1 == abort_at);
      exp_armed = (keeps >= pre_t) && (keeps < k);
      exp_we = (is_keep && !abort) ? mask : '0;
      exp_a = ADDR_W'((base + keeps) % DEPTH);
      if (is_keep && !abort && mask != '0) exp_q.push_back(exp_a);
      @(negedge clk);
      tests_run++;
      if (we !== exp_we || en !== exp_we) begin
        tests_failed++;
        $display("FAIL strobe keep#%0d: we=%b en=%b, need %b", keeps + 1, we, en, exp_we);
      end
      tests_run++;
      if (armed !== exp_armed || capture_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL status keep#%0d: armed=%b done=%b, need %b/0",
                 keeps, armed, capture_done, exp_armed);
      end
      tests_run++;
      if (addr !== exp_a) begin
        tests_failed++;
        $display("FAIL addr keep#%0d: got %0d, need %0d", keeps, addr, exp_a);
      end
      if (we !== '0) begin
        tests_run++;
        got_a = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        if (got_a !== addr) begin
          tests_failed++;
          $display("FAIL write_addr: wrote %0d, expected write %0d", addr, got_a);
        end
      end
      @(posedge clk); #1;
      if (smpl_vld) begin
        if (is_keep && abort) aborted = 1;
        else if (is_keep) keeps++;
        vcnt++;
      end
      abort = 1'b0;
    end
    trigger = 1'b0;
    tests_run++;
    if (cyc >= 20000 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL run_bound: cycles=%0d keeps=%0d unwritten=%0d, need %0d keeps",
               cyc, keeps, exp_q.size(), total);
    end
    model_addr = (base + keeps) % DEPTH;
    if (aborted) begin
      smpl_vld = 1'b1;
      @(negedge clk);
      tests_run++;
      if (armed !== 1'b0 || capture_done !== 1'b0 || we !== '0
          || addr !== ADDR_W'(model_addr)) begin
        tests_failed++;
        $display("FAIL after_abort: armed=%b done=%b we=%b addr=%0d, need 0/0/0/%0d",
                 armed, capture_done, we, addr, model_addr);
      end
      @(posedge clk); #1;
      smpl_vld = 1'b0;
      return;
    end
    // DONE hold: start and samples must not disturb anything.
    repeat (6) begin
      smpl_vld = 1'($urandom_range(0, 1));
      trigger = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      tests_run++;
      if (capture_done !== 1'b1 || armed !== 1'b0 || we !== '0 || en !== '0
          || addr !== ADDR_W'(model_addr)
          || trace_end !== ADDR_W'((model_addr + DEPTH - 1) % DEPTH)) begin
        tests_failed++;
        $display("FAIL done_hold: done=%b armed=%b we=%b addr=%0d te=%0d, need 1/0/0/%0d/%0d",
                 capture_done, armed, we, addr, trace_end, model_addr,
                 (model_addr + DEPTH - 1) % DEPTH);
      end
      @(posedge clk); #1;
    end
    start = 1'b0; smpl_vld = 1'b0; trigger = 1'b0;
    done_clr = 1'b1;
    @(posedge clk); #1;
    done_clr = 1'b0;
    @(negedge clk);
    tests_run++;
    if (capture_done !== 1'b0 || armed !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_clr: done=%b armed=%b, need 0/0", capture_done, armed);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_capture(0, 100, 3'b111, 450, 0, 0, 100, 1'b0);
  endtask

  task automatic test_decimation();
    int tp;
    tp = 50;
    run_capture(2, tp, 3'b111, DEPTH - tp + 1 + $urandom_range(0, 20), DEPTH - tp, 0, 100, 1'b0);
  endtask

  task automatic test_mask();
    run_capture(1, 1, 3'b101, DEPTH - 1 + 5, DEPTH - 1, 0, 70, 1'b0);
  endtask

  task automatic test_abort_post();
    int pre_t;
    pre_t = DEPTH - 200;
    run_capture(0, 200, 3'b111, pre_t + 10, 0, pre_t + 60, 100, 1'b0);
    run_capture(0, 300, 3'b011, DEPTH - 300 + 3, 0, 0, 90, 1'b0);
  endtask

  task automatic test_autoroll();
    int pre_t;
    pre_t = DEPTH - 100;
    run_capture(0, 100, 3'b111, 100000, 0, pre_t + 60, 100, 1'b1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int dp, tp;
      dp = $urandom_range(0, 2);
      tp = $urandom_range(1, DEPTH - 1);
      run_capture(dp, tp, 3'($urandom_range(1, 7)), DEPTH - tp + 1 + $urandom_range(0, 30),
                  DEPTH - tp, 0, $urandom_range(40, 100), 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    dec_pwr = '0; trig_pos = ADDR_W'(50); ch_mask = 3'b111; smpl_vld = 1'b1;
    trigger = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    tests_run++;
    if (we !== 3'b111) begin
      tests_failed++;
      $display("FAIL pre_reset_write: we=%b, need 111", we);
    end
    #2; rst_n = 1'b0; #1;
    tests_run++;
    if (we !== '0 || en !== '0 || addr !== '0 || armed !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: we=%b en=%b addr=%0d armed=%b, need 0", we, en, addr, armed);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (we !== '0 || addr !== '0) begin
      tests_failed++;
      $display("FAIL after_reset: we=%b addr=%0d, need 0/0", we, addr);
    end
    @(posedge clk); #1;
    smpl_vld = 1'b0;
    model_addr = 0;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    model_addr = 0;
    test_reset();
    test_basic();
    test_decimation();
    test_mask();
    test_abort_post();
    test_autoroll();
    test_random();
    test_reset_mid();
    run_capture(0, 20, 3'b110, DEPTH - 20 + 2, 0, 0, 100, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
